// File: rtl/poly_deriv_pkg.sv
// Shared types and helpers for the streaming polynomial differentiator.
// Holds the FSM state encoding, the default product width and the vanishing-term test.
package poly_deriv_pkg;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      MUL   = 2'd1,
      OUT   = 2'd2,
      FLUSH = 2'd3
   } state_t;

   localparam int DEF_COEF_W = 4;
   localparam int DEF_EXP_W  = 4;
   localparam int PROD_W     = DEF_COEF_W + DEF_EXP_W;

   // A term differentiates to zero when its coefficient or its exponent is zero.
   function automatic logic is_zero_term(input logic coef_zero, input logic exp_zero);
      return coef_zero | exp_zero;
   endfunction

endpackage

// File: rtl/shift_add_mul.sv
// Unsigned iterative shift-add multiplier with a fixed B_W-cycle latency.
// A start pulse loads the operands; done is high during the final iteration cycle.
module shift_add_mul #(
   parameter int A_W = 4,
   parameter int B_W = 4
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               start,
   input  logic [A_W-1:0]     a,
   input  logic [B_W-1:0]     b,
   output logic               done,
   output logic [A_W+B_W-1:0] product
);

   localparam int P_W = A_W + B_W;
   localparam int C_W = $clog2(B_W + 1);
   localparam logic [C_W-1:0] LAST_STEP = C_W'(B_W - 1);

   logic [P_W-1:0] mcand;
   logic [B_W-1:0] mplier;
   logic [C_W-1:0] step;
   logic           busy;

   assign done = busy && (step == LAST_STEP);

   // One multiplier bit per cycle; product settles at the edge that ends the done cycle.
   always_ff @(posedge clk) begin
      if (rst) begin
         mcand   <= '0;
         mplier  <= '0;
         step    <= '0;
         busy    <= 1'b0;
         product <= '0;
      end else if (start) begin
         mcand   <= P_W'(a);
         mplier  <= b;
         step    <= '0;
         busy    <= 1'b1;
         product <= '0;
      end else if (busy) begin
         if (mplier[0])
            product <= product + mcand;
         mcand  <= mcand << 1;
         mplier <= mplier >> 1;
         step   <= step + 1'b1;
         if (done)
            busy <= 1'b0;
      end
   end

endmodule

// File: rtl/poly_derivative_engine.sv
// Streaming differentiator: one (coef, exp) term in, one (coef*exp, exp-1) term out.
// Handles signed coefficients, vanishing-term suppression, frame flush and a per-frame term count.
module poly_derivative_engine
   import poly_deriv_pkg::*;
#(
   parameter int COEF_W    = 4,
   parameter int EXP_W     = 4,
   parameter bit SIGNED    = 1'b0,
   parameter bit DROP_ZERO = 1'b1,
   parameter int CNT_W     = 4
) (
   input  logic                    clk,
   input  logic                    rst,
   input  logic                    in_valid,
   output logic                    in_ready,
   input  logic [COEF_W-1:0]       in_coef,
   input  logic [EXP_W-1:0]        in_exp,
   input  logic                    in_last,
   output logic                    out_valid,
   input  logic                    out_ready,
   output logic [COEF_W+EXP_W-1:0] out_coef,
   output logic [EXP_W-1:0]        out_exp,
   output logic                    out_last,
   output logic [CNT_W-1:0]        term_count
);

   localparam int PW = COEF_W + EXP_W;

   state_t            state, state_nx;
   logic              neg_r, last_r, clear_pending;
   logic [EXP_W-1:0]  exp_r;
   logic              accept, out_fire, in_zero, in_drop, in_neg, mul_done;
   logic [COEF_W-1:0] in_mag;
   logic [PW-1:0]     product;

   assign in_ready = (state == IDLE) && !rst;
   assign accept   = in_valid && in_ready;
   assign in_zero  = is_zero_term(in_coef == '0, in_exp == '0);
   assign in_drop  = in_zero && DROP_ZERO;
   assign in_neg   = SIGNED && in_coef[COEF_W-1];
   assign in_mag   = in_neg ? (~in_coef + 1'b1) : in_coef;

   shift_add_mul #(.A_W(COEF_W), .B_W(EXP_W)) u_mul (
      .clk     (clk),
      .rst     (rst),
      .start   (accept && !in_drop),
      .a       (in_mag),
      .b       (in_exp),
      .done    (mul_done),
      .product (product)
   );

   always_ff @(posedge clk) begin
      if (rst)
         state <= IDLE;
      else
         state <= state_nx;
   end

   always_comb begin
      state_nx  = state;
      out_valid = 1'b0;
      case (state)
         IDLE:  if (accept) state_nx = in_drop ? (in_last ? FLUSH : IDLE) : MUL;
         MUL:   if (mul_done) state_nx = OUT;
         OUT:   begin
                   out_valid = 1'b1;
                   if (out_ready) state_nx = IDLE;
                end
         FLUSH: begin
                   out_valid = 1'b1;
                   if (out_ready) state_nx = IDLE;
                end
         default: state_nx = IDLE;
      endcase
   end

   // Zero-derivative terms carry exponent 0 so the exp==0 case never underflows.
   always_ff @(posedge clk) begin
      if (rst) begin
         neg_r  <= 1'b0;
         last_r <= 1'b0;
         exp_r  <= '0;
      end else if (accept) begin
         neg_r  <= in_neg;
         last_r <= in_last;
         exp_r  <= in_zero ? '0 : in_exp - 1'b1;
      end
   end

   assign out_coef = (state == OUT) ? (neg_r ? ('0 - product) : product) : '0;
   assign out_exp  = (state == OUT) ? exp_r : '0;
   assign out_last = out_valid && last_r;
   assign out_fire = out_valid && out_ready;

   // The count stays visible for one cycle after the frame's last term, then clears.
   always_ff @(posedge clk) begin
      if (rst) begin
         term_count    <= '0;
         clear_pending <= 1'b0;
      end else begin
         clear_pending <= out_fire && out_last;
         if (clear_pending)
            term_count <= '0;
         else if (out_fire && (out_coef != '0) && (term_count != '1))
            term_count <= term_count + 1'b1;
      end
   end

endmodule

// File: tb/tb_poly_derivative_engine.sv
// Directed bench for poly_derivative_engine: one unsigned/drop-zero instance and one
// signed/keep-zero instance share the input stream; each phase checks one of them.
module tb_poly_derivative_engine;
   import poly_deriv_pkg::*;

   logic              clk = 1'b0;
   logic              rst;
   logic              in_valid, in_last, out_ready;
   logic [3:0]        in_coef, in_exp;

   logic              u_in_ready, u_out_valid, u_out_last;
   logic [PROD_W-1:0] u_out_coef;
   logic [3:0]        u_out_exp, u_term_count;

   logic              s_in_ready, s_out_valid, s_out_last;
   logic [PROD_W-1:0] s_out_coef;
   logic [3:0]        s_out_exp, s_term_count;

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   poly_derivative_engine #(.COEF_W(4), .EXP_W(4), .SIGNED(1'b0), .DROP_ZERO(1'b1), .CNT_W(4)) u_dut (
      .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(u_in_ready), .in_coef(in_coef),
      .in_exp(in_exp), .in_last(in_last), .out_valid(u_out_valid), .out_ready(out_ready),
      .out_coef(u_out_coef), .out_exp(u_out_exp), .out_last(u_out_last), .term_count(u_term_count)
   );

   poly_derivative_engine #(.COEF_W(4), .EXP_W(4), .SIGNED(1'b1), .DROP_ZERO(1'b0), .CNT_W(4)) s_dut (
      .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(s_in_ready), .in_coef(in_coef),
      .in_exp(in_exp), .in_last(in_last), .out_valid(s_out_valid), .out_ready(out_ready),
      .out_coef(s_out_coef), .out_exp(s_out_exp), .out_last(s_out_last), .term_count(s_term_count)
   );

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic applyStimulus(input logic v, input logic [3:0] c, input logic [3:0] e, input logic l);
      in_valid = v;
      in_coef  = c;
      in_exp   = e;
      in_last  = l;
   endtask

   task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
      checks++;
      assert (observed === expected) else begin
         errors++;
         $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
      end
   endtask

   task automatic doReset();
      rst = 1'b1;
      tick();
      rst = 1'b0;
      #1;
   endtask

   initial begin
      rst       = 1'b1;
      out_ready = 1'b0;
      applyStimulus(1'b0, 4'd0, 4'd0, 1'b0);

      // Reset state
      tick();
      checkOutput("rst_in_ready",   32'(u_in_ready), 0);
      checkOutput("rst_out_valid",  32'(u_out_valid), 0);
      checkOutput("rst_out_coef",   32'(u_out_coef), 0);
      checkOutput("rst_out_exp",    32'(u_out_exp), 0);
      checkOutput("rst_out_last",   32'(u_out_last), 0);
      checkOutput("rst_term_count", 32'(u_term_count), 0);
      rst = 1'b0;
      #1;
      checkOutput("post_rst_in_ready", 32'(u_in_ready), 1);

      // Unsigned 5x^3 -> 15x^2, latency N+5
      $display("[TB] phase 1: unsigned single term");
      out_ready = 1'b1;
      applyStimulus(1'b1, 4'd5, 4'd3, 1'b1);
      tick();
      applyStimulus(1'b0, 4'd0, 4'd0, 1'b0);
      checkOutput("p1_busy_in_ready", 32'(u_in_ready), 0);
      checkOutput("p1_n1_valid",      32'(u_out_valid), 0);
      repeat (3) tick();
      checkOutput("p1_n4_valid",      32'(u_out_valid), 0);
      tick();
      checkOutput("p1_n5_valid",      32'(u_out_valid), 1);
      checkOutput("p1_coef",          32'(u_out_coef), 'h0F);
      checkOutput("p1_exp",           32'(u_out_exp), 2);
      checkOutput("p1_last",          32'(u_out_last), 1);
      tick();
      checkOutput("p1_count_before_clear", 32'(u_term_count), 1);
      checkOutput("p1_valid_after",        32'(u_out_valid), 0);
      checkOutput("p1_in_ready_after",     32'(u_in_ready), 1);
      tick();
      checkOutput("p1_count_cleared",      32'(u_term_count), 0);

      // Signed -3x^4 -> -12x^3, then a kept zero-derivative term
      $display("[TB] phase 2: signed and keep-zero");
      doReset();
      applyStimulus(1'b1, 4'hD, 4'd4, 1'b0);
      tick();
      applyStimulus(1'b0, 4'd0, 4'd0, 1'b0);
      repeat (4) tick();
      checkOutput("p2_valid", 32'(s_out_valid), 1);
      checkOutput("p2_coef",  32'(s_out_coef), 'hF4);
      checkOutput("p2_exp",   32'(s_out_exp), 3);
      checkOutput("p2_last",  32'(s_out_last), 0);
      tick();
      checkOutput("p2_count", 32'(s_term_count), 1);
      checkOutput("p2_in_ready", 32'(s_in_ready), 1);
      applyStimulus(1'b1, 4'd7, 4'd0, 1'b1);
      tick();
      applyStimulus(1'b0, 4'd0, 4'd0, 1'b0);
      repeat (4) tick();
      checkOutput("p2z_valid", 32'(s_out_valid), 1);
      checkOutput("p2z_coef",  32'(s_out_coef), 0);
      checkOutput("p2z_exp",   32'(s_out_exp), 0);
      checkOutput("p2z_last",  32'(s_out_last), 1);
      tick();
      checkOutput("p2z_count_no_incr", 32'(s_term_count), 1);
      tick();
      checkOutput("p2z_count_cleared", 32'(s_term_count), 0);

      // Drop-zero frame {7x^0, 0x^5, 2x^2} -> single term 4x^1
      $display("[TB] phase 3: drop-zero frame");
      doReset();
      applyStimulus(1'b1, 4'd7, 4'd0, 1'b0);
      tick();
      checkOutput("p3_drop1_in_ready", 32'(u_in_ready), 1);
      checkOutput("p3_drop1_valid",    32'(u_out_valid), 0);
      applyStimulus(1'b1, 4'd0, 4'd5, 1'b0);
      tick();
      checkOutput("p3_drop2_in_ready", 32'(u_in_ready), 1);
      checkOutput("p3_drop2_valid",    32'(u_out_valid), 0);
      applyStimulus(1'b1, 4'd2, 4'd2, 1'b1);
      tick();
      applyStimulus(1'b0, 4'd0, 4'd0, 1'b0);
      repeat (3) tick();
      checkOutput("p3_n4_valid", 32'(u_out_valid), 0);
      tick();
      checkOutput("p3_valid", 32'(u_out_valid), 1);
      checkOutput("p3_coef",  32'(u_out_coef), 4);
      checkOutput("p3_exp",   32'(u_out_exp), 1);
      checkOutput("p3_last",  32'(u_out_last), 1);
      tick();
      checkOutput("p3_count", 32'(u_term_count), 1);
      checkOutput("p3_valid_after", 32'(u_out_valid), 0);
      tick();
      checkOutput("p3_count_cleared", 32'(u_term_count), 0);

      // Lone vanishing last term -> flush terminator
      $display("[TB] phase 4: flush");
      applyStimulus(1'b1, 4'd9, 4'd0, 1'b1);
      tick();
      applyStimulus(1'b0, 4'd0, 4'd0, 1'b0);
      checkOutput("p4_valid", 32'(u_out_valid), 1);
      checkOutput("p4_coef",  32'(u_out_coef), 0);
      checkOutput("p4_exp",   32'(u_out_exp), 0);
      checkOutput("p4_last",  32'(u_out_last), 1);
      checkOutput("p4_count", 32'(u_term_count), 0);
      tick();
      checkOutput("p4_valid_after", 32'(u_out_valid), 0);
      checkOutput("p4_count_after", 32'(u_term_count), 0);
      tick();

      // Backpressure on 15x^15 -> 225x^14
      $display("[TB] phase 5: backpressure");
      out_ready = 1'b0;
      applyStimulus(1'b1, 4'd15, 4'd15, 1'b0);
      tick();
      applyStimulus(1'b0, 4'd0, 4'd0, 1'b0);
      repeat (4) tick();
      checkOutput("p5_valid", 32'(u_out_valid), 1);
      checkOutput("p5_coef",  32'(u_out_coef), 'hE1);
      checkOutput("p5_exp",   32'(u_out_exp), 14);
      for (int i = 0; i < 10; i++) begin
         applyStimulus(1'b1, 4'd3, 4'd3, 1'b1);
         tick();
         checkOutput("p5_hold_coef",     32'(u_out_coef), 'hE1);
         checkOutput("p5_hold_valid",    32'(u_out_valid), 1);
         checkOutput("p5_hold_in_ready", 32'(u_in_ready), 0);
      end
      applyStimulus(1'b0, 4'd0, 4'd0, 1'b0);
      out_ready = 1'b1;
      tick();
      checkOutput("p5_released_valid", 32'(u_out_valid), 0);
      checkOutput("p5_count",          32'(u_term_count), 1);
      checkOutput("p5_in_ready",       32'(u_in_ready), 1);
      repeat (6) tick();
      checkOutput("p5_no_stray_term",  32'(u_out_valid), 0);
      checkOutput("p5_count_held",     32'(u_term_count), 1);

      // Reset during the second multiply cycle
      $display("[TB] phase 6: reset mid-multiply");
      applyStimulus(1'b1, 4'd5, 4'd3, 1'b0);
      tick();
      applyStimulus(1'b0, 4'd0, 4'd0, 1'b0);
      tick();
      rst = 1'b1;
      tick();
      checkOutput("p6_valid_after_rst", 32'(u_out_valid), 0);
      checkOutput("p6_count_after_rst", 32'(u_term_count), 0);
      rst = 1'b0;
      #1;
      checkOutput("p6_in_ready", 32'(u_in_ready), 1);
      for (int i = 0; i < 6; i++) begin
         tick();
         checkOutput("p6_no_stale_term", 32'(u_out_valid), 0);
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/poly_derivative_engine.md
Name: poly_derivative_engine

Overview:
- Streaming polynomial differentiator: accepts one term (coefficient, exponent) per handshake and emits the derivative term (coefficient*exponent, exponent-1).
- Successor to the single-term combinational derivative block. Adds parametrised widths, signed coefficients, a sequential shift-add multiplier, valid/ready handshakes on both sides, frame delimiting, vanishing-term suppression and a per-frame term counter.
- Sits between the keypad/term-entry logic and the display formatter in the calculator datapath.

Parameters:
- COEF_W, 4, coefficient width in bits.
- EXP_W, 4, exponent width in bits; also the multiplier iteration count.
- SIGNED, 0, 1 = coefficient is two's complement; 0 = unsigned.
- DROP_ZERO, 1, 1 = suppress terms whose derivative is zero; 0 = emit them as coef 0, exp 0.
- CNT_W, 4, width of the emitted-term counter.

Ports:
- clk  in  1  single clock; all logic on the rising edge.
- rst  in  1  synchronous, active-high reset.
- in_valid  in  1  input term present.
- in_ready  out  1  engine can accept a term.
- in_coef  in  COEF_W  coefficient (base).
- in_exp  in  EXP_W  exponent (root), unsigned.
- in_last  in  1  final term of the polynomial frame.
- out_valid  out  1  derivative term present.
- out_ready  in  1  downstream accepts the term.
- out_coef  out  COEF_W+EXP_W  product coef*exp (sign-extended if SIGNED).
- out_exp  out  EXP_W  exponent minus 1.
- out_last  out  1  final term of the derivative frame.
- term_count  out  CNT_W  terms emitted in the current frame; saturates at all-ones.

Behaviour:
- Reset values:
  - in_ready=0 during the reset cycle, then 1.
  - out_valid=0, out_coef=0, out_exp=0, out_last=0, term_count=0.
  - FSM forced to IDLE.
- Reset mid-operation aborts any multiply or pending output; no partial term is emitted.
- FSM states and transitions:
  - IDLE: in_ready=1. On in_valid&in_ready, capture coef, exp and last.
    - If (coef==0 or exp==0) and DROP_ZERO=1: go to IDLE if last=0, else go to FLUSH.
    - Otherwise go to MUL.
  - MUL: in_ready=0. Unsigned shift-add over exactly EXP_W cycles on |coef| and exp; then go to OUT.
  - OUT: out_valid=1, outputs stable. On out_ready, go to IDLE.
  - FLUSH: emit coef 0, exp 0, out_last=1 so the frame terminator is never lost. On out_ready, go to IDLE.
- Arithmetic:
  - Product width is COEF_W+EXP_W; overflow is impossible.
  - SIGNED=1: multiply the magnitude, then negate if the coefficient was negative.
  - out_exp = exp-1; the exp==0 case never reaches the subtractor.
  - DROP_ZERO=0: a zero-derivative term is multiplied normally. The result coef is 0 and out_exp is forced to 0.
- Latency: handshake accepted in cycle N; out_valid first asserted in cycle N+1+EXP_W. Throughput is one term per EXP_W+2 cycles with out_ready held high.
- Backpressure: while out_valid=1 and out_ready=0, all out_* signals hold and in_ready stays 0.
- Counter:
  - term_count increments on each out handshake whose coef is nonzero, saturating at all-ones.
  - It clears in the cycle after an out handshake with out_last=1; the next frame starts from 0.
  - A FLUSH term does not count.
- Inputs are ignored whenever in_ready=0. in_valid is not required to be held.

Decomposition:
- Package poly_deriv_pkg holds:
  - FSM state enum: IDLE, MUL, OUT, FLUSH.
  - Width helper constant PROD_W = COEF_W+EXP_W.
  - Zero-term predicate function.
- Sub-module shift_add_mul:
  - Parametrised unsigned iterative multiplier with start/done; fixed EXP_W-cycle latency.
  - Owned by the engine; sign handling stays in the engine.

Test Plan:
- COEF_W=4, EXP_W=4, SIGNED=0: coef 5, exp 3, last 1 accepted at cycle N -> out_valid at N+5 with coef 15 (8'h0F), exp 2, last 1; term_count reads 1 before clearing.
- SIGNED=1: coef 4'b1101 (-3), exp 4 -> out_coef 8'hF4 (-12), exp 3.
- DROP_ZERO=1, frame {(7,0,last=0),(0,5,last=0),(2,2,last=1)} -> exactly one term (4, exp 1, last 1); in_ready returns 1 the cycle after each dropped term.
- DROP_ZERO=1, single term (9, exp 0, last=1) -> FLUSH term coef 0, exp 0, last 1; term_count stays 0.
- Backpressure: hold out_ready=0 for 10 cycles on the result for (15, 15) -> out_coef 8'hE1 stable throughout; in_ready=0; new in_valid ignored; one handshake when out_ready rises.
- Assert rst during the 2nd MUL cycle -> next cycle out_valid=0 and term_count=0; in_ready=1 the cycle after; no stale term appears.
